// File: rtl/fsk_pkg.sv
// Shared definitions for the 1000/1500 Hz FSK link: sample format, default
// comparator thresholds, receiver states and the modulator's sine tables.
package fsk_pkg;

  localparam int AMOSTRA_W = 8;
  localparam logic [AMOSTRA_W-1:0] MEIO_ESCALA = 8'd128;
  localparam logic [AMOSTRA_W-1:0] LIMIAR_ALTO_PADRAO  = 8'd160;
  localparam logic [AMOSTRA_W-1:0] LIMIAR_BAIXO_PADRAO = 8'd96;

  typedef enum logic {
    IDLE,
    RECEBE
  } estado_t;

  // One window of 1000 Hz: a single sine period, 128 + round(127*sin).
  localparam logic [AMOSTRA_W-1:0] SENO_1000 [32] = '{
    8'd128, 8'd153, 8'd177, 8'd199, 8'd218, 8'd234, 8'd245, 8'd253,
    8'd255, 8'd253, 8'd245, 8'd234, 8'd218, 8'd199, 8'd177, 8'd153,
    8'd128, 8'd103, 8'd79,  8'd57,  8'd38,  8'd22,  8'd11,  8'd3,
    8'd1,   8'd3,   8'd11,  8'd22,  8'd38,  8'd57,  8'd79,  8'd103
  };

  // One window of 1500 Hz: one and a half periods, starting at phase 0.
  localparam logic [AMOSTRA_W-1:0] SENO_1500 [32] = '{
    8'd128, 8'd165, 8'd199, 8'd226, 8'd245, 8'd254, 8'd253, 8'd240,
    8'd218, 8'd188, 8'd153, 8'd116, 8'd79,  8'd47,  8'd22,  8'd6,
    8'd1,   8'd6,   8'd22,  8'd47,  8'd79,  8'd116, 8'd153, 8'd188,
    8'd218, 8'd240, 8'd253, 8'd254, 8'd245, 8'd226, 8'd199, 8'd165
  };

  // Same sample shifted by half a period (mirror around midscale); used when
  // the modulator's phase has flipped after a 1500 Hz window.
  function automatic logic [AMOSTRA_W-1:0] inverte_fase(input logic [AMOSTRA_W-1:0] v);
    return AMOSTRA_W'(9'd256 - {1'b0, v});
  endfunction

endpackage

// File: rtl/fsk_comparador_histerese.sv
// Hysteresis comparator on the sample stream. nivel_o is the registered level
// before the current sample; evento_o flags a threshold crossing this cycle.
module fsk_comparador_histerese
  import fsk_pkg::*;
(
  input  logic                 clk,
  input  logic                 reset,
  input  logic [AMOSTRA_W-1:0] amostra_i,
  input  logic                 amostra_valida_i,
  input  logic [AMOSTRA_W-1:0] limiar_alto_i,
  input  logic [AMOSTRA_W-1:0] limiar_baixo_i,
  output logic                 nivel_o,
  output logic                 evento_o
);

  logic nivel_q, nivel_d;

  // Next level and crossing pulse; only strobed samples can move the level.
  always_comb begin
    // NOTE: every output of this block gets a default first, so no path can
    // leave one unassigned and infer a latch.
    nivel_d  = nivel_q;
    evento_o = 1'b0;
    if (amostra_valida_i) begin
      if (!nivel_q && (amostra_i >= limiar_alto_i)) begin
        nivel_d  = 1'b1;
        evento_o = 1'b1;
      end else if (nivel_q && (amostra_i <= limiar_baixo_i)) begin
        nivel_d  = 1'b0;
        evento_o = 1'b1;
      end
    end
  end

  // Level register, cleared to low by the synchronous reset.
  always_ff @(posedge clk) begin
    // NOTE: non-blocking assignment for state, so all registers update from
    // the same pre-edge values regardless of statement order.
    if (reset) nivel_q <= 1'b0;
    else       nivel_q <= nivel_d;
  end

  assign nivel_o = nivel_q;

endmodule

// File: rtl/fsk_demodulador.sv
// FSK receiver: counts hysteresis crossings over 32-sample windows, decides
// one bit per window and tracks carrier presence.
module fsk_demodulador
  import fsk_pkg::*;
#(
  parameter int                   AMOSTRAS_SIMBOLO = 32,
  parameter logic [AMOSTRA_W-1:0] LIMIAR_ALTO      = LIMIAR_ALTO_PADRAO,
  parameter logic [AMOSTRA_W-1:0] LIMIAR_BAIXO     = LIMIAR_BAIXO_PADRAO,
  parameter int                   CRUZ_LIMIAR      = 3,
  parameter int                   JANELAS_PERDA    = 2
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic [AMOSTRA_W-1:0] amostra,
  input  logic                 amostra_valida,
  output logic                 dado,
  output logic                 dado_valido,
  output logic                 portadora,
  output logic [2:0]           n_cruz
);

  localparam int CNT_W = $clog2(AMOSTRAS_SIMBOLO);
  localparam int SIL_W = $clog2(JANELAS_PERDA + 1);
  localparam logic [CNT_W-1:0] ULTIMA_AMOSTRA = CNT_W'(AMOSTRAS_SIMBOLO - 1);

  estado_t          estado_q, estado_d;
  logic [CNT_W-1:0] cnt_amostra_q, cnt_amostra_d;
  logic [5:0]       cnt_cruz_q, cnt_cruz_d;
  logic [SIL_W-1:0] silencio_q, silencio_d;
  logic             dado_q, dado_d;
  logic             dado_valido_q, dado_valido_d;
  logic [2:0]       n_cruz_q, n_cruz_d;

  logic       nivel;
  logic       evento;
  logic       subida;
  logic [5:0] cruz_total;

  fsk_comparador_histerese u_comparador (
    .clk              (clk),
    .reset            (reset),
    .amostra_i        (amostra),
    .amostra_valida_i (amostra_valida),
    .limiar_alto_i    (LIMIAR_ALTO),
    .limiar_baixo_i   (LIMIAR_BAIXO),
    .nivel_o          (nivel),
    .evento_o         (evento)
  );

  // A crossing from a low level is a rising edge; the count including the
  // current sample is what a closing window decides on.
  assign subida     = evento & ~nivel;
  assign cruz_total = cnt_cruz_q + 6'(evento);

  // Next state: window entry on a rising crossing, counting, window close,
  // bit decision and carrier-loss detection.
  always_comb begin
    estado_d      = estado_q;
    cnt_amostra_d = cnt_amostra_q;
    cnt_cruz_d    = cnt_cruz_q;
    silencio_d    = silencio_q;
    dado_d        = dado_q;
    dado_valido_d = 1'b0;
    n_cruz_d      = n_cruz_q;

    if (amostra_valida) begin
      case (estado_q)
        IDLE: begin
          // The triggering sample is sample 0 of the first window.
          if (subida) begin
            estado_d      = RECEBE;
            cnt_amostra_d = CNT_W'(1);
            cnt_cruz_d    = 6'd1;
            silencio_d    = '0;
          end
        end
        RECEBE: begin
          cnt_amostra_d = cnt_amostra_q + 1'b1;
          cnt_cruz_d    = cruz_total;
          if (cnt_amostra_q == ULTIMA_AMOSTRA) begin
            dado_d        = (cruz_total >= 6'(CRUZ_LIMIAR));
            n_cruz_d      = (cruz_total > 6'd7) ? 3'd7 : cruz_total[2:0];
            dado_valido_d = 1'b1;
            cnt_amostra_d = '0;
            cnt_cruz_d    = '0;
            if (cruz_total != 6'd0) begin
              silencio_d = '0;
            end else if (int'(silencio_q) + 1 >= JANELAS_PERDA) begin
              // Carrier lost: this window still reports its (zero) decision.
              estado_d   = IDLE;
              silencio_d = '0;
            end else begin
              silencio_d = silencio_q + 1'b1;
            end
          end
        end
        default: estado_d = IDLE;
      endcase
    end
  end

  // State and output registers with synchronous reset; a reset mid-window
  // simply discards the partial count.
  always_ff @(posedge clk) begin
    if (reset) begin
      estado_q      <= IDLE;
      cnt_amostra_q <= '0;
      cnt_cruz_q    <= '0;
      silencio_q    <= '0;
      dado_q        <= 1'b0;
      dado_valido_q <= 1'b0;
      n_cruz_q      <= '0;
    end else begin
      estado_q      <= estado_d;
      cnt_amostra_q <= cnt_amostra_d;
      cnt_cruz_q    <= cnt_cruz_d;
      silencio_q    <= silencio_d;
      dado_q        <= dado_d;
      dado_valido_q <= dado_valido_d;
      n_cruz_q      <= n_cruz_d;
    end
  end

  assign dado        = dado_q;
  assign dado_valido = dado_valido_q;
  assign portadora   = (estado_q == RECEBE);
  assign n_cruz      = n_cruz_q;

endmodule
